seg_scan_ctrl: RTL and testbench

//  Time-multiplexed scan scheduler that shares one 7-segment cathode bus among the
//  6 HH:MM:SS digits. Each digit gets its time slot in turn, with a guard gap between

---
 rtl/rtc_pkg.sv | 21 ++
 rtl/seg_scan_ctrl_if.sv | 28 ++
 rtl/scan_slot_timer.sv | 31 +++
 rtl/seg_scan_ctrl.sv | 165 ++++++++++++++++
 tb/tb_seg_scan_ctrl.sv | 168 ++++++++++++++++
 5 files changed

// File: rtl/rtc_pkg.sv
// Shared constants and types for the multiplexed HH:MM:SS display path.
package rtc_pkg;

  localparam int NUM_DIGITS = 6;
  localparam int SEG_W      = 7;

  typedef logic [SEG_W-1:0] seg_t;

  localparam seg_t                  SEG_OFF = 7'h7F;
  localparam logic [NUM_DIGITS-1:0] AN_OFF  = 6'h3F;

  typedef enum logic [1:0] {IDLE, ON, GUARD} scan_state_t;

  // Active-low one-hot anode pattern for the given digit index.
  function automatic logic [NUM_DIGITS-1:0] an_sel(input logic [2:0] idx);
    logic [NUM_DIGITS-1:0] one;
    one = NUM_DIGITS'(1);
    return ~(one << idx);
  endfunction

endpackage

// File: rtl/seg_scan_ctrl_if.sv
// Display-side bundle between the digit decoders and the scan scheduler.
// The bright signal exists only when RTC_SCAN_DIM_EN is defined.
interface seg_scan_ctrl_if;
  import rtc_pkg::*;

  logic                    en;
  seg_t [NUM_DIGITS-1:0]   digit_seg;
  logic [NUM_DIGITS-1:0]   blink_mask;
`ifdef RTC_SCAN_DIM_EN
  logic [2:0]              bright;
`endif
  seg_t                    seg_o;
  logic [NUM_DIGITS-1:0]   an_o;
  logic                    frame_done;

`ifdef RTC_SCAN_DIM_EN
  modport master (output en, digit_seg, blink_mask, bright,
                  input  seg_o, an_o, frame_done);
  modport slave  (input  en, digit_seg, blink_mask, bright,
                  output seg_o, an_o, frame_done);
`else
  modport master (output en, digit_seg, blink_mask,
                  input  seg_o, an_o, frame_done);
  modport slave  (input  en, digit_seg, blink_mask,
                  output seg_o, an_o, frame_done);
`endif

endinterface

// File: rtl/scan_slot_timer.sv
// Loadable down-counter timing the ON and GUARD slots; done flags the last cycle of a slot.
module scan_slot_timer #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             run,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  output logic [CNT_W-1:0] cnt,
  output logic             done
);

  logic [CNT_W-1:0] cnt_nxt;

  always_comb begin
    cnt_nxt = cnt;
    if (load)
      cnt_nxt = load_val;
    else if (run && (cnt != '0))
      cnt_nxt = cnt - 1'b1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) cnt <= '0;
    else      cnt <= cnt_nxt;
  end

  assign done = run && (cnt == '0);

endmodule

// File: rtl/seg_scan_ctrl.sv
// Six-digit 7-segment scan scheduler with guard gaps, frame snapshots and blink.
// Define RTC_SCAN_DIM_EN to add the bright input and per-slot dimming.
module seg_scan_ctrl
  import rtc_pkg::*;
#(
  parameter int DWELL_CYC    = 50000,
  parameter int GUARD_CYC    = 500,
  parameter int BLINK_FRAMES = 83
) (
  input  logic            clk,
  input  logic            rst,
  seg_scan_ctrl_if.slave  bus
);

  localparam int MAX_CYC = (DWELL_CYC > GUARD_CYC) ? DWELL_CYC : GUARD_CYC;
  localparam int TMR_W   = $clog2(MAX_CYC);
  localparam int FCNT_W  = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

  localparam logic [TMR_W-1:0]  DWELL_LD  = TMR_W'(DWELL_CYC - 1);
  localparam logic [TMR_W-1:0]  GUARD_LD  = TMR_W'(GUARD_CYC - 1);
  localparam logic [FCNT_W-1:0] FCNT_LAST = FCNT_W'(BLINK_FRAMES - 1);
  localparam logic [2:0]        LAST_IDX  = 3'(NUM_DIGITS - 1);

  localparam logic [1:0] ST_IDLE  = 2'(IDLE);
  localparam logic [1:0] ST_ON    = 2'(ON);
  localparam logic [1:0] ST_GUARD = 2'(GUARD);

  logic [1:0]             state, state_nxt;
  logic [2:0]             idx, idx_nxt;
  seg_t [NUM_DIGITS-1:0]  snap, snap_nxt;
  logic                   blink_phase, phase_nxt;
  logic [FCNT_W-1:0]      frame_cnt, fcnt_nxt;
  logic [2:0]             bright_nxt;
`ifdef RTC_SCAN_DIM_EN
  logic [2:0]             snap_bright;
`endif

  seg_t                   seg_q, seg_nxt;
  logic [NUM_DIGITS-1:0]  an_q, an_nxt;
  logic                   fd_q, fd_nxt;

  logic                   tmr_load, tmr_done;
  logic [TMR_W-1:0]       tmr_val, tmr_cnt, elapsed_nxt;
  logic [31:0]            dim_lim;
  logic                   lit;

  scan_slot_timer #(.CNT_W(TMR_W)) u_timer (
    .clk      (clk),
    .rst      (rst),
    .run      (state != ST_IDLE),
    .load     (tmr_load),
    .load_val (tmr_val),
    .cnt      (tmr_cnt),
    .done     (tmr_done)
  );

  // Next-state decode; enable loss overrides every state.
  always_comb begin
    state_nxt = state;
    idx_nxt   = idx;
    snap_nxt  = snap;
    phase_nxt = blink_phase;
    fcnt_nxt  = frame_cnt;
    fd_nxt    = 1'b0;
    tmr_load  = 1'b0;
    tmr_val   = DWELL_LD;
`ifdef RTC_SCAN_DIM_EN
    bright_nxt = snap_bright;
`else
    bright_nxt = 3'd7;
`endif
    if (!bus.en) begin
      state_nxt = ST_IDLE;
      idx_nxt   = '0;
    end else begin
      case (state)
        ST_IDLE: begin
          state_nxt = ST_ON;
          idx_nxt   = '0;
          snap_nxt  = bus.digit_seg;
`ifdef RTC_SCAN_DIM_EN
          bright_nxt = bus.bright;
`endif
          tmr_load  = 1'b1;
        end
        ST_ON: begin
          if (tmr_done) begin
            state_nxt = ST_GUARD;
            tmr_load  = 1'b1;
            tmr_val   = GUARD_LD;
          end
        end
        ST_GUARD: begin
          if (tmr_done) begin
            state_nxt = ST_ON;
            tmr_load  = 1'b1;
            if (idx != LAST_IDX) begin
              idx_nxt = idx + 1'b1;
            end else begin
              idx_nxt  = '0;
              snap_nxt = bus.digit_seg;
`ifdef RTC_SCAN_DIM_EN
              bright_nxt = bus.bright;
`endif
              fd_nxt   = 1'b1;
              if (frame_cnt == FCNT_LAST) begin
                fcnt_nxt  = '0;
                phase_nxt = ~blink_phase;
              end else begin
                fcnt_nxt  = frame_cnt + 1'b1;
              end
            end
          end
        end
        default: begin
          state_nxt = ST_IDLE;
          idx_nxt   = '0;
        end
      endcase
    end
  end

  // Outputs are decoded from next-state values so the registered pins line up with the state.
  always_comb begin
    elapsed_nxt = tmr_load ? '0 : (DWELL_LD - tmr_cnt + 1'b1);
    dim_lim     = ((32'(bright_nxt) + 32'd1) * 32'(DWELL_CYC)) >> 3;
    lit         = (state_nxt == ST_ON) && !(bus.blink_mask[idx_nxt] && phase_nxt)
                  && (32'(elapsed_nxt) < dim_lim);
    seg_nxt     = lit ? ~snap_nxt[idx_nxt] : SEG_OFF;
    an_nxt      = lit ? an_sel(idx_nxt) : AN_OFF;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= ST_IDLE;
      idx         <= '0;
      snap        <= '0;
      blink_phase <= 1'b0;
      frame_cnt   <= '0;
      seg_q       <= SEG_OFF;
      an_q        <= AN_OFF;
      fd_q        <= 1'b0;
`ifdef RTC_SCAN_DIM_EN
      snap_bright <= '0;
`endif
    end else begin
      state       <= state_nxt;
      idx         <= idx_nxt;
      snap        <= snap_nxt;
      blink_phase <= phase_nxt;
      frame_cnt   <= fcnt_nxt;
      seg_q       <= seg_nxt;
      an_q        <= an_nxt;
      fd_q        <= fd_nxt;
`ifdef RTC_SCAN_DIM_EN
      snap_bright <= bright_nxt;
`endif
    end
  end

  assign bus.seg_o      = seg_q;
  assign bus.an_o       = an_q;
  assign bus.frame_done = fd_q;

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Scoreboard bench for seg_scan_ctrl: per-cycle expected pins queued from the frame timing.
module tb_seg_scan_ctrl;
  import rtc_pkg::*;

  localparam int DW = 8;
  localparam int GD = 2;
  localparam int BF = 2;

  typedef struct {
    logic [5:0] an;
    logic [6:0] seg;
    logic       fd;
    string      tag;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;
  exp_t sb[$];

  seg_scan_ctrl_if bus ();

  seg_scan_ctrl #(.DWELL_CYC(DW), .GUARD_CYC(GD), .BLINK_FRAMES(BF)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic push(input logic [5:0] an, input logic [6:0] seg, input logic fd,
                      input string tag);
    exp_t e;
    e.an = an; e.seg = seg; e.fd = fd; e.tag = tag;
    sb.push_back(e);
  endtask

  task automatic push_off(input int n, input string tag);
    repeat (n) push(AN_OFF, SEG_OFF, 1'b0, tag);
  endtask

  // One full frame: 6 slots of DW cycles (first 'lit' cycles lit unless dark) plus GD guard cycles.
  task automatic push_frame(input logic [5:0][6:0] pats, input logic [5:0] dark,
                            input logic fd_first, input int lit, input string tag);
    logic [5:0] one;
    logic       fd_e;
    one = 6'b000001;
    for (int d = 0; d < 6; d++) begin
      for (int c = 0; c < DW; c++) begin
        fd_e = fd_first && (d == 0) && (c == 0);
        if (dark[d] || (c >= lit)) push(AN_OFF, SEG_OFF, fd_e, tag);
        else                       push(~(one << d), ~pats[d], fd_e, tag);
      end
      push_off(GD, tag);
    end
  endtask

  task automatic step();
    exp_t e;
    @(negedge clk);
    checks++;
    assert (sb.size() > 0) else begin
      errors++;
      $error("FAIL scoreboard: queue size got %0d expected nonzero", sb.size());
    end
    if (sb.size() > 0) begin
      e = sb.pop_front();
      checks++;
      assert (bus.an_o === e.an && bus.seg_o === e.seg && bus.frame_done === e.fd) else begin
        errors++;
        $error("FAIL %s: an/seg/fd got %h/%h/%b expected %h/%h/%b", e.tag,
               bus.an_o, bus.seg_o, bus.frame_done, e.an, e.seg, e.fd);
      end
    end
    checks++;
    assert ($countones(~bus.an_o) <= 1) else begin
      errors++;
      $error("FAIL onehot: an_o got %h expected at most one low bit", bus.an_o);
    end
  endtask

  task automatic check_n(input int n);
    repeat (n) step();
  endtask

  task automatic drain();
    while (sb.size() > 0) step();
  endtask

  // Holds reset with en already high, checks the dark pins, then releases at a falling edge.
  task automatic do_reset(input logic [5:0][6:0] pats, input logic [5:0] mask);
    sb.delete();
    rst = 1'b0;
    bus.en = 1'b1;
    bus.digit_seg = pats;
    bus.blink_mask = mask;
    push_off(3, "reset");
    check_n(3);
    rst = 1'b1;
  endtask

  initial begin
    logic [5:0][6:0] p1, p2, z0, z1;
    rst = 1'b1;
    bus.en = 1'b0;
    bus.digit_seg = '0;
    bus.blink_mask = '0;
`ifdef RTC_SCAN_DIM_EN
    bus.bright = 3'd7;
`endif
    #2 rst = 1'b0;

    p1 = {7'h6F, 7'h07, 7'h6D, 7'h66, 7'h4F, 7'h5B};
    p2 = {7'h3F, 7'h06, 7'h7F, 7'h77, 7'h39, 7'h71};
    z0 = '0; z0[0] = 7'h3F;
    z1 = '0; z1[0] = 7'h06;

    // Reset timing, then free-running frames with frame_done and idx wrap.
    do_reset(p1, 6'b0);
    push_frame(p1, 6'b0, 1'b0, DW, "t1_first");
    for (int f = 0; f < 3; f++) push_frame(p1, 6'b0, 1'b1, DW, "t3_run");
    drain();

    // Snapshot holds mid-frame; the change shows only in the next frame.
    do_reset(z0, 6'b0);
    push_frame(z0, 6'b0, 1'b0, DW, "t2_f0");
    check_n(3 * (DW + GD) + 2);
    bus.digit_seg[0] = 7'h06;
    push_frame(z1, 6'b0, 1'b1, DW, "t2_f1");
    drain();

    // Blink: digits 0-1 dark in frames 2-3.
    do_reset(p1, 6'b000011);
    for (int f = 0; f < 6; f++)
      push_frame(p1, (f == 2 || f == 3) ? 6'b000011 : 6'b0, f > 0, DW, "t4_blink");
    drain();

    // Enable drop mid-slot at idx 4, then restart with a fresh snapshot.
    do_reset(p1, 6'b0);
    push_frame(p1, 6'b0, 1'b0, DW, "t5_pre");
    check_n(4 * (DW + GD) + 3);
    bus.en = 1'b0;
    sb.delete();
    push_off(5, "t5_off");
    check_n(5);
    bus.digit_seg = p2;
    bus.en = 1'b1;
    push_frame(p2, 6'b0, 1'b0, DW, "t5_restart");
    push_frame(p2, 6'b0, 1'b1, DW, "t5_next");
    drain();

`ifdef RTC_SCAN_DIM_EN
    // Dimming: bright 3 lights half the dwell, bright 7 the full dwell.
    bus.bright = 3'd3;
    do_reset(p1, 6'b0);
    push_frame(p1, 6'b0, 1'b0, 4, "t6_b3");
    check_n(5);
    bus.bright = 3'd7;
    push_frame(p1, 6'b0, 1'b1, DW, "t6_b7");
    drain();
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
